instruction_dump_tx: RTL and testbench



---
 rtl/instruction_dump_tx.sv | 134 +++++++++++++
 tb/tb_instruction_dump_tx.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/instruction_dump_tx.sv
// instruction_dump_tx: reads an instruction memory image word by word and
// sends it over UART 8N1, high byte first, so the host can verify it.
module instruction_dump_tx #(
    parameter int CLKS_PER_BAUD = 868,
    parameter int WORDS         = 32
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        start,
    input  logic [15:0] mem_data,
    output logic [7:0]  mem_addr,
    output logic        UART_RXD_OUT,
    output logic        busy,
    output logic        done
);

    localparam int BW = (CLKS_PER_BAUD > 1) ? $clog2(CLKS_PER_BAUD) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BAUD - 1);
    localparam logic [7:0]    ADDR_LAST = 8'(WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND_HI,
        S_SEND_LO,
        S_FIN
    } state_t;

    state_t          r_state, w_state_n;
    logic [BW-1:0]   r_baud, w_baud_n;
    logic [3:0]      r_bit, w_bit_n;
    logic [15:0]     r_shadow, w_shadow_n;
    logic [7:0]      r_addr, w_addr_n;
    logic            r_tx, w_tx_n;
    logic            r_busy, w_busy_n;
    logic            r_done, w_done_n;
    logic [7:0]      w_byte;
    logic [2:0]      w_didx;
    logic            w_sending;

    // State, counters, shadow word and registered outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= S_IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shadow <= '0;
            r_addr   <= '0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_baud   <= w_baud_n;
            r_bit    <= w_bit_n;
            r_shadow <= w_shadow_n;
            r_addr   <= w_addr_n;
            r_tx     <= w_tx_n;
            r_busy   <= w_busy_n;
            r_done   <= w_done_n;
        end
    end

    // Next state; outputs are derived from the next state so they register
    always_comb begin
        w_state_n  = r_state;
        w_baud_n   = r_baud;
        w_bit_n    = r_bit;
        w_shadow_n = r_shadow;
        w_addr_n   = r_addr;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_n = S_LOAD;
                    w_addr_n  = '0;
                end
            end
            S_LOAD: begin
                w_shadow_n = mem_data;
                w_baud_n   = '0;
                w_bit_n    = '0;
                w_state_n  = S_SEND_HI;
            end
            S_SEND_HI, S_SEND_LO: begin
                if (r_baud == BAUD_LAST) begin
                    w_baud_n = '0;
                    if (r_bit == 4'd9) begin
                        w_bit_n = '0;
                        if (r_state == S_SEND_HI) begin
                            w_state_n = S_SEND_LO;
                        end else if (r_addr != ADDR_LAST) begin
                            w_addr_n  = r_addr + 8'd1;
                            w_state_n = S_LOAD;
                        end else begin
                            w_state_n = S_FIN;
                        end
                    end else begin
                        w_bit_n = r_bit + 4'd1;
                    end
                end else begin
                    w_baud_n = r_baud + BW'(1);
                end
            end
            S_FIN: begin
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        w_sending = (w_state_n == S_SEND_HI) || (w_state_n == S_SEND_LO);
        w_byte    = (w_state_n == S_SEND_HI) ? w_shadow_n[15:8] : w_shadow_n[7:0];
        w_didx    = 3'(w_bit_n - 4'd1);
        w_tx_n    = 1'b1;
        if (w_sending) begin
            if (w_bit_n == 4'd0) begin
                w_tx_n = 1'b0;
            end else if (w_bit_n == 4'd9) begin
                w_tx_n = 1'b1;
            end else begin
                w_tx_n = w_byte[w_didx];
            end
        end
        w_busy_n = w_sending || (w_state_n == S_LOAD);
        w_done_n = (w_state_n == S_FIN);
    end

    assign mem_addr     = r_addr;
    assign UART_RXD_OUT = r_tx;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_instruction_dump_tx.sv
// tb_instruction_dump_tx: per-cycle comparison of the serial line and
// status outputs against a timing/frame model built from arithmetic.
module tb_instruction_dump_tx;

    logic        clk;
    logic        rst_n;
    logic        start_a, start_b;
    logic [15:0] mem_a [0:31];
    logic [15:0] mem_b;
    logic [15:0] data_a, data_b;
    logic [7:0]  addr_a, addr_b;
    logic        line_a, line_b;
    logic        busy_a, busy_b;
    logic        done_a, done_b;

    int total = 0;
    int bad   = 0;

    assign data_a = mem_a[addr_a[4:0]];
    assign data_b = mem_b;

    instruction_dump_tx #(.CLKS_PER_BAUD(4), .WORDS(32)) dut_a (
        .CLK(clk), .RST_N(rst_n), .start(start_a), .mem_data(data_a),
        .mem_addr(addr_a), .UART_RXD_OUT(line_a), .busy(busy_a),
        .done(done_a)
    );

    instruction_dump_tx #(.CLKS_PER_BAUD(2), .WORDS(1)) dut_b (
        .CLK(clk), .RST_N(rst_n), .start(start_b), .mem_data(data_b),
        .mem_addr(addr_b), .UART_RXD_OUT(line_b), .busy(busy_b),
        .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Line level at offset r inside one word period (LOAD + two frames)
    function automatic logic exp_line(int r, int c, logic [15:0] w);
        int q, f, b;
        logic [7:0] byt;
        if (r == 0) return 1'b1;
        q   = r - 1;
        f   = q / (10 * c);
        b   = (q % (10 * c)) / c;
        byt = (f == 0) ? w[15:8] : w[7:0];
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return byt[b-1];
    endfunction

    function automatic logic [10:0] obs(int sel);
        if (sel != 0) return {line_b, busy_b, done_b, addr_b};
        return {line_a, busy_a, done_a, addr_a};
    endfunction

    task automatic check_outs(input string tag, input int sel,
                              input logic el, input logic eb,
                              input logic ed, input logic [7:0] ea);
        logic [10:0] o;
        o = obs(sel);
        chk({tag, "_line"}, 32'(o[10]), 32'(el));
        chk({tag, "_busy"}, 32'(o[9]), 32'(eb));
        chk({tag, "_done"}, 32'(o[8]), 32'(ed));
        chk({tag, "_addr"}, 32'(o[7:0]), 32'(ea));
    endtask

    task automatic dump(input int sel, input bit hold, input bit corrupt,
                        input int rst_at);
        int c, w, p, k, r;
        logic [15:0] img [0:31];
        c = (sel != 0) ? 2 : 4;
        w = (sel != 0) ? 1 : 32;
        p = 1 + 20 * c;
        for (int i = 0; i < 32; i++) img[i] = (sel != 0) ? mem_b : mem_a[i];
        if (sel != 0) start_b = 1'b1; else start_a = 1'b1;
        for (int d = 0; d <= w * p; d++) begin
            @(negedge clk);
            if (d == 0 && !hold) begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
            if (d == w * p) begin
                check_outs("fin", sel, 1'b1, 1'b0, 1'b1, 8'(w - 1));
            end else begin
                k = d / p;
                r = d % p;
                check_outs("run", sel, exp_line(r, c, img[k]), 1'b1, 1'b0,
                           8'(k));
            end
            if (corrupt && d == 4) mem_a[0] = 16'hFFFF;
            if (d == rst_at) begin
                #2 rst_n = 1'b0;
                #1;
                check_outs("rst", sel, 1'b1, 1'b0, 1'b0, 8'd0);
                start_a = 1'b0;
                start_b = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
        start_a = 1'b0;
        start_b = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check_outs("idle", sel, 1'b1, 1'b0, 1'b0, 8'(w - 1));
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        mem_b   = 16'h40AA;
        for (int i = 0; i < 32; i++) mem_a[i] = 16'($urandom);
        mem_a[0] = 16'h40AA;
        repeat (3) @(negedge clk);
        check_outs("reset_a", 0, 1'b1, 1'b0, 1'b0, 8'd0);
        check_outs("reset_b", 1, 1'b1, 1'b0, 1'b0, 8'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        dump(0, 1'b0, 1'b1, -1);

        for (int i = 0; i < 32; i++) mem_a[i] = 16'(i * 257);
        dump(0, 1'b1, 1'b0, -1);
        dump(0, 1'b0, 1'b0, -1);

        dump(1, 1'b0, 1'b0, -1);
        mem_b = 16'($urandom);
        dump(1, 1'b1, 1'b0, -1);

        for (int i = 0; i < 32; i++) mem_a[i] = 16'($urandom);
        dump(0, 1'b0, 1'b0, 81 + 18);
        repeat (2) @(negedge clk);
        check_outs("post_rst", 0, 1'b1, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 32; i++) mem_a[i] = 16'($urandom);
        dump(0, 1'b0, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
